match_serializer: RTL and testbench

Downstream stage of the 4-lane character detector. Accepts one packed `detect_t [3:0]` word per handshake (per lane: a 4-bit `index` and a `match` flag). Emits one output beat per lane whose `match` is set, lowest lane first, over a valid/ready stream. Also keeps a saturating count of emitted matches.

---
 rtl/detect_pkg.sv | 15 +
 rtl/lowest_set_encoder.sv | 23 ++
 rtl/match_serializer.sv | 128 ++++++++++++
 tb/tb_match_serializer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
// Types and constants shared by the 4-lane character detector and its downstream serializer.
package detect_pkg;
   localparam int DETECT_LANES   = 4;
   localparam int DETECT_INDEX_W = 4;

   typedef struct packed {
      logic [DETECT_INDEX_W-1:0] index;
      logic                      match;
   } detect_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } ser_state_t;
endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational priority encoder: locates the lowest set bit of a mask and reports what remains.
module lowest_set_encoder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]         mask,
   output logic [$clog2(WIDTH)-1:0] idx,
   output logic                     any,
   output logic [WIDTH-1:0]         one_hot_clear,
   output logic                     single
);
   always_comb begin
      idx           = '0;
      any           = |mask;
      one_hot_clear = mask & (mask - WIDTH'(1));
      single        = any && (one_hot_clear == '0);
      // Descending scan so the lowest set bit wins.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = i[$clog2(WIDTH)-1:0];
         end
      end
   end
endmodule

// File: rtl/match_serializer.sv
// Serializes the matching lanes of each detector word into one valid/ready beat per match, lowest lane first.
module match_serializer
   import detect_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int INDEX_W = 4,
   parameter int COUNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*(INDEX_W+1)-1:0]  in_chars,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(LANES)-1:0]      out_lane,
   output logic [INDEX_W-1:0]            out_index,
   output logic                          out_last,
   output logic [COUNT_W-1:0]            match_count
);
   localparam int LW     = INDEX_W + 1;
   localparam int LANE_W = $clog2(LANES);
   localparam int WORD_W = LANES * LW;

   ser_state_t          r_state;
   ser_state_t          w_state_nxt;
   logic [LANES-1:0]    r_rest;
   logic [WORD_W-1:0]   r_word;
   logic                r_out_valid;
   logic [LANE_W-1:0]   r_out_lane;
   logic [INDEX_W-1:0]  r_out_index;
   logic                r_out_last;
   logic [COUNT_W-1:0]  r_count;

   logic                w_accept;
   logic                w_hs;
   logic                w_load;
   logic [LANES-1:0]    w_in_mask;
   logic [LANES-1:0]    w_mask_nxt;
   logic [WORD_W-1:0]   w_word_nxt;
   logic [LANE_W-1:0]   w_idx;
   logic                w_any;
   logic [LANES-1:0]    w_clear;
   logic                w_single;
   logic [INDEX_W-1:0]  w_index_nxt;

   assign in_ready    = (r_state == ST_IDLE) || (w_hs && r_out_last);
   assign w_hs        = r_out_valid && out_ready;
   assign w_accept    = in_valid && in_ready;
   assign w_load      = w_accept || w_hs;
   assign w_word_nxt  = w_accept ? in_chars : r_word;
   // r_rest already excludes the lane on the output, so a handshake simply advances to it.
   assign w_mask_nxt  = w_accept ? w_in_mask : r_rest;

   always_comb begin
      w_in_mask = '0;
      for (int g = 0; g < LANES; g++) begin
         w_in_mask[g] = in_chars[g*LW];
      end
   end

   lowest_set_encoder #(
      .WIDTH (LANES)
   ) u_enc (
      .mask          (w_mask_nxt),
      .idx           (w_idx),
      .any           (w_any),
      .one_hot_clear (w_clear),
      .single        (w_single)
   );

   always_comb begin
      w_index_nxt = '0;
      for (int g = 0; g < LANES; g++) begin
         if (w_idx == LANE_W'(g)) begin
            w_index_nxt = w_word_nxt[g*LW+1 +: INDEX_W];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_load) begin
         w_state_nxt = w_any ? ST_EMIT : ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output fields are loaded only on accept or handshake, which keeps them frozen during stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word      <= '0;
         r_rest      <= '0;
         r_out_valid <= 1'b0;
         r_out_lane  <= '0;
         r_out_index <= '0;
         r_out_last  <= 1'b0;
         r_count     <= '0;
      end else begin
         if (w_accept) begin
            r_word <= in_chars;
         end
         if (w_load) begin
            r_rest      <= w_clear;
            r_out_valid <= w_any;
            r_out_lane  <= w_idx;
            r_out_index <= w_index_nxt;
            r_out_last  <= w_single;
         end
         if (w_hs && (r_count != '1)) begin
            r_count <= r_count + COUNT_W'(1);
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_lane    = r_out_lane;
   assign out_index   = r_out_index;
   assign out_last    = r_out_last;
   assign match_count = r_count;
endmodule

// File: tb/tb_match_serializer.sv
// Bench for match_serializer: directed scenarios plus random traffic against a queue-based beat model.
module tb_match_serializer;
   localparam int W = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_chars = '0;

   logic          in_ready, out_valid, out_last;
   logic [1:0]    out_lane;
   logic [3:0]    out_index;
   logic [15:0]   match_count;

   logic          s_in_ready, s_out_valid, s_out_last;
   logic [1:0]    s_out_lane;
   logic [3:0]    s_out_index;
   logic [2:0]    s_match_count;

   match_serializer #(.LANES(4), .INDEX_W(4), .COUNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_chars(in_chars),
      .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane), .out_index(out_index),
      .out_last(out_last), .match_count(match_count)
   );

   match_serializer #(.LANES(4), .INDEX_W(4), .COUNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_chars(in_chars),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_lane(s_out_lane), .out_index(s_out_index),
      .out_last(s_out_last), .match_count(s_match_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] lane;
      logic [3:0] index;
      logic       last;
   } beat_t;

   beat_t        q[$];
   int unsigned  m_count = 0;
   logic         armed = 1'b0;
   int           n_checks = 0;
   int           n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] mk(input logic [3:0] m, input logic [15:0] idx);
      logic [W-1:0] w;
      w = '0;
      for (int g = 0; g < 4; g++) begin
         w[g*5 +: 5] = {idx[g*4 +: 4], m[g]};
      end
      return w;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Model: each accepted word becomes a list of beats; beats leave on handshakes.
   always @(negedge clk) begin : cmp
      logic        exp_ready;
      logic        exp_valid;
      int          hi;
      beat_t       b;
      if (rst) begin
         q.delete();
         m_count = 0;
      end else if (armed) begin
         exp_valid = (q.size() != 0);
         exp_ready = (q.size() == 0) || ((q.size() == 1) && out_ready);
         chk("m_in_ready", in_ready, exp_ready);
         chk("m_out_valid", out_valid, exp_valid);
         chk("m_s_in_ready", s_in_ready, exp_ready);
         chk("m_s_out_valid", s_out_valid, exp_valid);
         if (exp_valid) begin
            chk("m_lane", out_lane, q[0].lane);
            chk("m_index", out_index, q[0].index);
            chk("m_last", out_last, q[0].last);
            chk("m_s_lane", s_out_lane, q[0].lane);
         end
         chk("m_count", match_count, m_count);
         chk("m_count_sat", s_match_count, (m_count > 7) ? 7 : m_count);
         if (exp_valid && out_ready) begin
            void'(q.pop_front());
            m_count++;
         end
         if (in_valid && exp_ready) begin
            hi = -1;
            for (int g = 0; g < 4; g++) if (in_chars[g*5]) hi = g;
            for (int g = 0; g < 4; g++) begin
               if (in_chars[g*5]) begin
                  b.lane  = 2'(g);
                  b.index = in_chars[g*5+1 +: 4];
                  b.last  = (g == hi);
                  q.push_back(b);
               end
            end
         end
      end
   end

   initial begin
      repeat (3) cyc();
      rst = 1'b0;
      armed = 1'b1;

      // Idle after reset
      @(negedge clk);
      chk("rst_lane", out_lane, 0);
      chk("rst_index", out_index, 0);
      chk("rst_last", out_last, 0);
      chk("rst_count", match_count, 0);
      for (int i = 0; i < 10; i++) begin
         chk("idle_valid", out_valid, 0);
         chk("idle_ready", in_ready, 1);
         cyc();
         @(negedge clk);
      end

      // Lanes 0 and 2
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_chars  = mk(4'b0101, 16'h0A03);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("two_b1_valid", out_valid, 1);
      chk("two_b1_lane", out_lane, 0);
      chk("two_b1_index", out_index, 4'h3);
      chk("two_b1_last", out_last, 0);
      cyc();
      @(negedge clk);
      chk("two_b2_valid", out_valid, 1);
      chk("two_b2_lane", out_lane, 2);
      chk("two_b2_index", out_index, 4'hA);
      chk("two_b2_last", out_last, 1);
      cyc();
      @(negedge clk);
      chk("two_count", match_count, 2);
      chk("two_done", out_valid, 0);

      // All four lanes with a toggling consumer
      cyc();
      in_valid = 1'b1;
      in_chars = mk(4'b1111, 16'h4321);
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         out_ready = (i % 2 == 0);
         @(negedge clk);
         chk("a4_ready", in_ready, (i == 6));
         chk("a4_lane", out_lane, (i + 1) / 2);
         chk("a4_index", out_index, (i + 1) / 2 + 1);
         cyc();
      end
      @(negedge clk);
      chk("a4_count", match_count, 6);

      // Back-to-back accept on the last beat
      cyc();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_chars  = mk(4'b0001, 16'h0003);
      cyc();
      in_chars  = mk(4'b1000, 16'hF000);
      @(negedge clk);
      chk("bb_ready", in_ready, 1);
      chk("bb_last", out_last, 1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bb_valid", out_valid, 1);
      chk("bb_lane", out_lane, 3);
      chk("bb_index", out_index, 4'hF);
      chk("bb_last2", out_last, 1);
      cyc();

      // Zero-match word dropped in one cycle
      in_valid = 1'b1;
      in_chars = mk(4'b0000, 16'h7777);
      cyc();
      in_chars = mk(4'b0010, 16'h0070);
      @(negedge clk);
      chk("zero_valid", out_valid, 0);
      chk("zero_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("zero_b_valid", out_valid, 1);
      chk("zero_b_lane", out_lane, 1);
      chk("zero_b_index", out_index, 4'h7);
      cyc();

      // Reset with two matches pending
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_chars  = mk(4'b1010, 16'h5060);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("rmid_valid", out_valid, 1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rmid_no_beat", out_valid, 0);
         chk("rmid_count", match_count, 0);
         cyc();
      end

      // Nine matches: the 3-bit counter pins at 7
      for (int w = 0; w < 3; w++) begin
         in_valid = 1'b1;
         in_chars = (w < 2) ? mk(4'b1111, 16'h9876) : mk(4'b0001, 16'h0005);
         cyc();
         in_valid = 1'b0;
         repeat ((w < 2) ? 4 : 1) cyc();
      end
      @(negedge clk);
      chk("sat_count_s", s_match_count, 7);
      chk("sat_count", match_count, 9);
      cyc();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_chars  = W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) cyc();
      @(negedge clk);
      chk("drain_empty", out_valid, 0);
      chk("drain_sat", s_match_count, 7);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
